// File: rtl/requantizer.sv
// Narrowing stage: drops FRAC_DROP LSBs with round-half-up, then saturates to WL_OUT signed bits.
// Two-stage valid/ready pipeline with per-sample, sticky and counted saturation reporting.
module requantizer #(
  parameter int WL_IN     = 20,
  parameter int WL_OUT    = 16,
  parameter int FRAC_DROP = 2,
  parameter int CNT_W     = 8
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic signed [WL_IN-1:0]  in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [WL_OUT-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sat,
  output logic                     sat_sticky,
  output logic [CNT_W-1:0]         sat_count,
  input  logic                     sat_clr
);
  localparam int STAGES = 2;
  localparam int RW     = WL_IN + 1;
  // Half an output LSB; collapses to zero when nothing is dropped.
  localparam logic signed [RW-1:0] RND  = RW'((64'd1 << FRAC_DROP) >> 1);
  localparam logic signed [RW-1:0] MAXV = RW'((64'd1 << (WL_OUT-1)) - 64'd1);
  localparam logic signed [RW-1:0] MINV = -MAXV - RW'(1);

  logic [STAGES:1]           vld_pipe;
  logic signed [RW-1:0]      r1;
  logic signed [RW-1:0]      q;
  logic signed [WL_OUT-1:0]  dat_nx;
  logic                      sat_nx;
  logic                      en;
  logic                      sat_ev;

  assign en        = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];
  assign sat_ev    = en && vld_pipe[1] && sat_nx;

  always_comb begin
    q      = r1 >>> FRAC_DROP;
    sat_nx = 1'b0;
    dat_nx = q[WL_OUT-1:0];
    if (q > MAXV) begin
      sat_nx = 1'b1;
      dat_nx = MAXV[WL_OUT-1:0];
    end else if (q < MINV) begin
      sat_nx = 1'b1;
      dat_nx = MINV[WL_OUT-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      vld_pipe <= '0;
      r1       <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      // Extra sign bit keeps the rounding add from wrapping at the positive rail.
      r1       <= $signed({in_data[WL_IN-1], in_data}) + RND;
      out_data <= dat_nx;
      out_sat  <= vld_pipe[1] && sat_nx;
    end
  end

  // An event in the same cycle as a clear lands after the clear.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sat_sticky <= 1'b0;
      sat_count  <= '0;
    end else if (sat_ev) begin
      sat_sticky <= 1'b1;
      if (sat_clr)
        sat_count <= CNT_W'(1);
      else if (sat_count != '1)
        sat_count <= sat_count + CNT_W'(1);
    end else if (sat_clr) begin
      sat_sticky <= 1'b0;
      sat_count  <= '0;
    end
  end
endmodule

// File: doc/requantizer.md
Name: requantizer

Overview:
- Narrowing stage for the Chebyshev evaluation datapath; the inverse of the widening adder stage.
- Takes a widened signed accumulator word, drops FRAC_DROP LSBs with round-half-up, and saturates to WL_OUT signed bits.
- Two-stage pipeline with valid/ready handshake on both sides.
- Saturation events are flagged per sample, held in a sticky flag, and counted.

Parameters:
- WL_IN, 20, word length of in_data (signed two's complement).
- WL_OUT, 16, word length of out_data (signed). Constraint: WL_OUT <= WL_IN - FRAC_DROP.
- FRAC_DROP, 2, number of LSBs removed by rounding. 0 means no rounding; truncation/saturation only.
- CNT_W, 8, width of the saturation event counter.

Ports:
- clock, input, 1, single system clock; all state updates on the rising edge.
- resetn, input, 1, synchronous active-low reset.
- in_data, input, WL_IN, signed sample.
- in_valid, input, 1, in_data valid.
- in_ready, output, 1, block accepts in_data this cycle.
- out_data, output, WL_OUT, rounded and saturated sample.
- out_valid, output, 1, out_data valid.
- out_ready, input, 1, downstream accepts out_data.
- out_sat, output, 1, current out_data was saturated; qualified by out_valid.
- sat_sticky, output, 1, a saturation has occurred since the last reset or clear.
- sat_count, output, CNT_W, number of saturation events; saturates at 2^CNT_W-1.
- sat_clr, input, 1, clears sat_sticky and sat_count.

Behaviour:
- Reset (resetn=0 at a clock edge): all pipeline valids=0; out_data=0, out_valid=0, out_sat=0, sat_sticky=0, sat_count=0. Reset mid-operation discards in-flight samples. in_ready=1 in the first cycle after reset.
- Advance enable: en = !out_valid || out_ready. in_ready = en (combinational). The pipeline moves only when en=1; on stall, every stage holds data and valid unchanged.
- Input transfer: the cycle with in_valid && in_ready.
- Stage 1 (on en): register v1=in_valid and r1 = sext(in_data, WL_IN+1) + (FRAC_DROP>0 ? 2^(FRAC_DROP-1) : 0). The WL_IN+1 width prevents wrap on the rounding add.
- Stage 2 (on en): register out_valid=v1 and q = r1 >>> FRAC_DROP (arithmetic shift, floor). Saturation rules:
  - q > 2^(WL_OUT-1)-1: out_data=2^(WL_OUT-1)-1, sat=1.
  - q < -2^(WL_OUT-1): out_data=-2^(WL_OUT-1), sat=1.
  - otherwise out_data=q[WL_OUT-1:0], sat=0.
  - out_sat=sat when v1, else 0.
- Rounding mode: half-up, toward +inf on ties. Example: 1.5→2, -1.5→-1.
- Latency: 2 cycles from input transfer to out_valid when no stall. Throughput: 1 sample per cycle.
- Saturation event: out_sat=1 at the cycle the sample enters stage 2 (counted once, not per stall cycle).
- Event effects: sat_sticky←1; sat_count increments unless already at all-ones, where it holds.
- sat_clr=1 at an edge: sat_sticky←0, sat_count←0. If an event occurs in the same cycle, the event wins after the clear: sat_sticky=1, sat_count=1.
- Bubbles: out_valid=0 while out_ready=0 does not stall the pipeline, because en=1.
- out_data and out_sat hold their value while out_valid && !out_ready.

Test Plan:
- Default params. Inputs 6, -6, 131068, then 0 → out_data 2, -1, 32767 (out_sat=0 for all), then 0. Each sample appears exactly 2 cycles after its transfer.
- Inputs 131070, -131076, 524287, -524288, -131072 → 32767, -32768, 32767, -32768, -32768. out_sat=1,1,1,1,0. sat_count=4, sat_sticky=1.
- Back-to-back stream of 8 samples with out_ready held low for cycles 3–5 → in_ready low on the same cycles. No sample lost or duplicated, order preserved, and each saturation is counted once.
- Drive 300 saturating samples with CNT_W=8 → sat_count stops at 255. Pulse sat_clr in the same cycle as a saturating sample → sat_count=1, sat_sticky=1.
- Assert resetn=0 for 1 cycle with 2 samples in flight → out_valid=0 and all counters/flags 0 on the next cycle; the next input produces output after 2 cycles.
- FRAC_DROP=0, WL_IN=18, WL_OUT=16. Inputs 40000 and -40000 → 32767 and -32768, both with out_sat=1. Input 5 → 5.
